// File: rtl/servo_pkg.sv
// Shared constants and setpoint helper for the servo frame generator and the
// left/right PWM comparators.
package servo_pkg;

    localparam int CNTR_W = 12;
    localparam int X_W    = 11;

    localparam logic [X_W-1:0] X_MIN    = 11'd1000;
    localparam logic [X_W-1:0] X_MAX    = 11'd2000;
    localparam logic [X_W-1:0] X_CENTER = 11'd1500;

    // Offset an averaged sample into the setpoint range and clamp at the top.
    // One extra bit on the sum keeps the comparison honest for any sample width.
    function automatic logic [X_W-1:0] clamp_setpoint(input logic [X_W-1:0] avg);
        logic [X_W:0] raw;
        raw = {1'b0, avg} + {1'b0, X_MIN};
        if (raw > {1'b0, X_MAX}) begin
            return X_MAX;
        end else begin
            return raw[X_W-1:0];
        end
    endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// Prescaler producing a 1 us tick and the free-running PWM frame counter.
module servo_tick_gen
    import servo_pkg::*;
#(
    parameter int CLK_DIV     = 100,
    parameter int FRAME_TICKS = 3000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              tick,
    output logic [CNTR_W-1:0] cntr_val,
    output logic              frame_start
);

    localparam int PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PRESC_W-1:0] presc_r;
    logic [CNTR_W-1:0]  cntr_r;
    logic               frame_start_r;
    logic               tick_s;
    logic               last_tick_s;

    assign tick_s      = (presc_r == PRESC_W'(CLK_DIV - 1));
    assign last_tick_s = (cntr_r == CNTR_W'(FRAME_TICKS - 1));

    // Prescaler, frame counter and the wrap pulse that marks cntr_val returning to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r       <= {PRESC_W{1'b0}};
            cntr_r        <= {CNTR_W{1'b0}};
            frame_start_r <= 1'b0;
        end else begin
            if (tick_s) begin
                presc_r <= {PRESC_W{1'b0}};
                if (last_tick_s) begin
                    cntr_r <= {CNTR_W{1'b0}};
                end else begin
                    cntr_r <= cntr_r + CNTR_W'(1);
                end
            end else begin
                presc_r <= presc_r + PRESC_W'(1);
            end
            frame_start_r <= tick_s & last_tick_s;
        end
    end

    assign tick        = tick_s;
    assign cntr_val    = cntr_r;
    assign frame_start = frame_start_r;

endmodule

// File: rtl/servo_frame_gen.sv
// Frame counter plus setpoint pipeline: 4-sample SPI average, offset/clamp into
// a pending register, committed to x_val only at frame wrap, with a stale-input
// fallback to centre.
module servo_frame_gen
    import servo_pkg::*;
#(
    parameter int CLK_DIV      = 100,
    parameter int FRAME_TICKS  = 3000,
    parameter int SAMPLE_W     = 10,
    parameter int AVG_LOG2     = 2,
    parameter int STALE_FRAMES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] spi_data,
    input  logic                spi_valid,
    output logic [CNTR_W-1:0]   cntr_val,
    output logic [X_W-1:0]      x_val,
    output logic                frame_start,
    output logic                overrun,
    output logic                stale
);

    localparam int ACC_W   = 12;
    localparam int ACNT_W  = AVG_LOG2;
    localparam int STALE_W = $clog2(STALE_FRAMES + 1);

    logic               tick_s;
    logic               wrap_s;
    logic               avg_done_s;
    logic               stale_force_s;
    logic [ACC_W-1:0]   sum_s;
    logic [X_W-1:0]     avg_s;

    logic [ACC_W-1:0]   acc_r,       acc_nxt_s;
    logic [ACNT_W-1:0]  acc_cnt_r,   acc_cnt_nxt_s;
    logic [X_W-1:0]     pending_r,   pending_nxt_s;
    logic               pending_vld_r, pending_vld_nxt_s;
    logic [STALE_W-1:0] stale_cnt_r, stale_cnt_nxt_s;
    logic               stale_r,     stale_nxt_s;
    logic [X_W-1:0]     x_r,         x_nxt_s;
    logic               overrun_r,   overrun_nxt_s;

    servo_tick_gen #(
        .CLK_DIV     (CLK_DIV),
        .FRAME_TICKS (FRAME_TICKS)
    ) u_tick_gen (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick_s),
        .cntr_val    (cntr_val),
        .frame_start (frame_start)
    );

    // The edge on which cntr_val returns to 0 (and frame_start rises).
    assign wrap_s        = tick_s & (cntr_val == CNTR_W'(FRAME_TICKS - 1));
    assign avg_done_s    = spi_valid & (acc_cnt_r == {ACNT_W{1'b1}});
    assign sum_s         = acc_r + ACC_W'(spi_data);
    assign avg_s         = X_W'(sum_s >> AVG_LOG2);
    // A sample arriving on the would-be stale wrap keeps the input alive.
    assign stale_force_s = wrap_s & ~spi_valid & (stale_cnt_r == STALE_W'(STALE_FRAMES - 1));

    // Next-state for averager, pending slot, committed setpoint and stale tracking.
    always_comb begin
        acc_nxt_s         = acc_r;
        acc_cnt_nxt_s     = acc_cnt_r;
        pending_nxt_s     = pending_r;
        pending_vld_nxt_s = pending_vld_r;
        stale_cnt_nxt_s   = stale_cnt_r;
        stale_nxt_s       = stale_r;
        x_nxt_s           = x_r;
        overrun_nxt_s     = 1'b0;

        if (spi_valid) begin
            stale_cnt_nxt_s = {STALE_W{1'b0}};
            stale_nxt_s     = 1'b0;
        end else if (wrap_s && (stale_cnt_r != STALE_W'(STALE_FRAMES))) begin
            stale_cnt_nxt_s = stale_cnt_r + STALE_W'(1);
        end else begin
            stale_cnt_nxt_s = stale_cnt_r;
        end

        if (stale_force_s) begin
            x_nxt_s           = X_CENTER;
            stale_nxt_s       = 1'b1;
            pending_vld_nxt_s = 1'b0;
            acc_nxt_s         = {ACC_W{1'b0}};
            acc_cnt_nxt_s     = {ACNT_W{1'b0}};
        end else begin
            // Frame takes whatever was pending before this edge.
            if (wrap_s && pending_vld_r) begin
                x_nxt_s           = pending_r;
                pending_vld_nxt_s = 1'b0;
            end else begin
                x_nxt_s = x_r;
            end
            // A completed average always lands in the pending slot; overwriting
            // an unused value outside a wrap is reported as overrun.
            if (avg_done_s) begin
                pending_nxt_s     = clamp_setpoint(avg_s);
                pending_vld_nxt_s = 1'b1;
                acc_nxt_s         = {ACC_W{1'b0}};
                acc_cnt_nxt_s     = {ACNT_W{1'b0}};
                overrun_nxt_s     = pending_vld_r & ~wrap_s;
            end else if (spi_valid) begin
                acc_nxt_s     = sum_s;
                acc_cnt_nxt_s = acc_cnt_r + ACNT_W'(1);
            end else begin
                acc_nxt_s     = acc_r;
                acc_cnt_nxt_s = acc_cnt_r;
            end
        end
    end

    // State registers for the setpoint pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r         <= {ACC_W{1'b0}};
            acc_cnt_r     <= {ACNT_W{1'b0}};
            pending_r     <= {X_W{1'b0}};
            pending_vld_r <= 1'b0;
            stale_cnt_r   <= {STALE_W{1'b0}};
            stale_r       <= 1'b0;
            x_r           <= X_CENTER;
            overrun_r     <= 1'b0;
        end else begin
            acc_r         <= acc_nxt_s;
            acc_cnt_r     <= acc_cnt_nxt_s;
            pending_r     <= pending_nxt_s;
            pending_vld_r <= pending_vld_nxt_s;
            stale_cnt_r   <= stale_cnt_nxt_s;
            stale_r       <= stale_nxt_s;
            x_r           <= x_nxt_s;
            overrun_r     <= overrun_nxt_s;
        end
    end

    assign x_val   = x_r;
    assign overrun = overrun_r;
    assign stale   = stale_r;

endmodule

// File: tb/tb_servo_frame_gen.sv
// Directed bench for servo_frame_gen with a shortened frame (4 clk/tick,
// 20 ticks/frame) so the stale scenario stays short.
module tb_servo_frame_gen;

    localparam int CLK_DIV     = 4;
    localparam int FRAME_TICKS = 20;
    localparam int FRAME_CLKS  = CLK_DIV * FRAME_TICKS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  spi_data = 10'd0;
    logic        spi_valid = 1'b0;
    logic [11:0] cntr_val;
    logic [10:0] x_val;
    logic        frame_start;
    logic        overrun;
    logic        stale;

    int compared   = 0;
    int mismatched = 0;

    servo_frame_gen #(
        .CLK_DIV      (CLK_DIV),
        .FRAME_TICKS  (FRAME_TICKS),
        .SAMPLE_W     (10),
        .AVG_LOG2     (2),
        .STALE_FRAMES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_data    (spi_data),
        .spi_valid   (spi_valid),
        .cntr_val    (cntr_val),
        .x_val       (x_val),
        .frame_start (frame_start),
        .overrun     (overrun),
        .stale       (stale)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] d);
        spi_data  = d;
        spi_valid = 1'b1;
        @(posedge clk);
        #1;
        spi_valid = 1'b0;
    endtask

    task automatic send4(input logic [9:0] d);
        for (int i = 0; i < 4; i++) send(d);
    endtask

    task automatic wait_fs(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 3 * FRAME_CLKS; i++) begin
            @(posedge clk);
            #1;
            if (frame_start === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check(tag, {31'd0, found}, 32'd1);
    endtask

    initial begin
        // Reset state and frame counter timing
        repeat (3) @(posedge clk);
        #1;
        check("rst_cntr", cntr_val, 0);
        check("rst_x", x_val, 1500);
        check("rst_fs", frame_start, 0);
        check("rst_stale", stale, 0);
        check("rst_ovr", overrun, 0);
        rst = 1'b0;
        step(3);
        check("cntr_before_tick", cntr_val, 0);
        step(1);
        check("cntr_first_tick", cntr_val, 1);
        step(FRAME_CLKS - 5);
        check("cntr_last", cntr_val, FRAME_TICKS - 1);
        check("fs_before_wrap", frame_start, 0);
        step(1);
        check("cntr_wrap", cntr_val, 0);
        check("fs_at_wrap", frame_start, 1);
        step(1);
        check("fs_one_cycle", frame_start, 0);

        // Averaging mid-frame, commit at next frame
        send(10'd400); send(10'd400); send(10'd400);
        check("pend_vld_before_4th", dut.pending_vld_r, 0);
        send(10'd400);
        check("pend_after_4th", dut.pending_r, 1400);
        check("pend_vld_after_4th", dut.pending_vld_r, 1);
        check("x_hold_midframe", x_val, 1500);
        wait_fs("wait_fs_t2");
        check("x_commit_1400", x_val, 1400);

        // Truncation and clamping at both ends
        send(10'd1); send(10'd2); send(10'd3); send(10'd4);
        wait_fs("wait_fs_trunc");
        check("x_trunc_1002", x_val, 1002);
        send4(10'd1023);
        wait_fs("wait_fs_max");
        check("x_clamp_2000", x_val, 2000);
        send4(10'd0);
        wait_fs("wait_fs_min");
        check("x_min_1000", x_val, 1000);
        check("ovr_idle", overrun, 0);

        // Two averages in one frame -> overrun, newest wins
        send4(10'd100);
        check("ovr_first_avg", overrun, 0);
        send4(10'd200);
        check("ovr_pulse", overrun, 1);
        step(1);
        check("ovr_one_cycle", overrun, 0);
        wait_fs("wait_fs_ovr");
        check("x_after_ovr_1200", x_val, 1200);

        // Average completing on the wrap edge
        send4(10'd300);
        check("ovr_t5_setup", overrun, 0);
        send(10'd600); send(10'd600); send(10'd600);
        step(FRAME_CLKS - 8);
        check("cntr_pre_wrap_t5", cntr_val, FRAME_TICKS - 1);
        send(10'd600);
        check("fs_coincident", frame_start, 1);
        check("x_takes_old_1300", x_val, 1300);
        check("pend_new_1600", dut.pending_r, 1600);
        check("pend_vld_new", dut.pending_vld_r, 1);
        check("ovr_coincident", overrun, 0);
        wait_fs("wait_fs_t5");
        check("x_next_1600", x_val, 1600);

        // Stale fallback after 16 silent frames
        send4(10'd800);
        wait_fs("wait_fs_t6");
        check("x_1800", x_val, 1800);
        for (int i = 2; i <= 15; i++) wait_fs("wait_fs_silent");
        check("x_still_1800", x_val, 1800);
        check("stale_not_yet", stale, 0);
        wait_fs("wait_fs_16th");
        check("x_stale_center", x_val, 1500);
        check("stale_set", stale, 1);
        check("pend_vld_cleared", dut.pending_vld_r, 0);
        wait_fs("wait_fs_17th");
        check("stale_held", stale, 1);
        check("x_stale_held", x_val, 1500);
        send(10'd700);
        check("stale_cleared", stale, 0);
        send(10'd700); send(10'd700); send(10'd700);
        wait_fs("wait_fs_fresh");
        check("x_fresh_1700", x_val, 1700);

        // Asynchronous reset mid-frame
        step(10);
        rst = 1'b1;
        #1;
        check("mid_rst_cntr", cntr_val, 0);
        check("mid_rst_x", x_val, 1500);
        check("mid_rst_fs", frame_start, 0);
        check("mid_rst_stale", stale, 0);
        step(2);
        rst = 1'b0;
        step(3);
        check("post_rst_fs", frame_start, 0);
        check("post_rst_cntr", cntr_val, 0);
        step(1);
        check("post_rst_tick", cntr_val, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
